// File: rtl/speedy_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : speedy_pkg                                                |
// | Purpose  : Shared types, phase encodings, P_K helper and round-      |
// |            constant ROM for the Speedy-6-192 AC/AK scheduler.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package speedy_pkg;

  localparam int NCOL = 32;
  localparam int NROW = 6;
  localparam int W    = NCOL * NROW;

  // Phase reported alongside each scheduled word
  localparam logic [1:0] PH_WHITEN = 2'd0;
  localparam logic [1:0] PH_ROUND  = 2'd1;
  localparam logic [1:0] PH_FINAL  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WHITEN = 2'd1,
    ST_ROUND  = 2'd2,
    ST_FINAL  = 2'd3
  } state_t;

  localparam int RC_DEPTH = 15;

  // Round constants: consecutive 32-bit words of the fractional hex
  // expansion of pi, six words per constant, first word in the MSBs.
  localparam logic [W-1:0] RC_ROM [RC_DEPTH] = '{
    {32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344, 32'hA4093822, 32'h299F31D0},
    {32'h082EFA98, 32'hEC4E6C89, 32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C},
    {32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917, 32'h9216D5D9, 32'h8979FB1B},
    {32'hD1310BA6, 32'h98DFB5AC, 32'h2FFD72DB, 32'hD01ADFB7, 32'hB8E1AFED, 32'h6A267E96},
    {32'hBA7C9045, 32'hF12C7F99, 32'h24A19947, 32'hB3916CF7, 32'h0801F2E2, 32'h858EFC16},
    {32'h636920D8, 32'h71574E69, 32'hA458FEA3, 32'hF4933D7E, 32'h0D95748F, 32'h728EB658},
    {32'h718BCD58, 32'h82154AEE, 32'h7B54A41D, 32'hC25A59B5, 32'h9C30D539, 32'h2AF26013},
    {32'hC5D1B023, 32'h286085F0, 32'hCA417918, 32'hB8DB38EF, 32'h8E79DCB0, 32'h603A180E},
    {32'h6C9E0E8B, 32'hB01E8A3E, 32'hD71577C1, 32'hBD314B27, 32'h78AF2FDA, 32'h55605C60},
    {32'hE65525F3, 32'hAA55AB94, 32'h57489862, 32'h63E81440, 32'h55CA396A, 32'h2AAB10B6},
    {32'hB4CC5C34, 32'h1141E8CE, 32'hA15486AF, 32'h7C72E993, 32'hB3EE1411, 32'h636FBC2A},
    {32'h2BA9C55D, 32'h741831F6, 32'hCE5C3E16, 32'h9B87931E, 32'hAFD6BA33, 32'h6C24CF5C},
    {32'h7A325381, 32'h28958677, 32'h3B8F4898, 32'h6B4BB9AF, 32'hC4BFE81B, 32'h66282193},
    {32'h61D809CC, 32'hFB21A991, 32'h487CAC60, 32'h5DEC8032, 32'hEF845D5D, 32'hE98575B1},
    {32'hDC262302, 32'hEB651B88, 32'h23893E81, 32'hD396ACC5, 32'h0F6D6FF3, 32'h83F44239}
  };

  // P_K: bit j of the key moves to position (7*j+1) mod W
  function automatic logic [W-1:0] pk_perm(input logic [W-1:0] k);
    logic [W-1:0] p;
    p = '0;
    for (int j = 0; j < W; j++) begin
      p[(7 * j + 1) % W] = k[j];
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/speedy_ac_ak_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : speedy_ac_ak_sched_if                                     |
// | Purpose  : Key-load and AC/AK word handshake bundle between the      |
// |            datapath controller (master) and the scheduler (slave).   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface speedy_ac_ak_sched_if;
  import speedy_pkg::*;

  logic         key_valid;
  logic         key_ready;
  logic [W-1:0] key_in;
  logic         adv;
  logic         ak_valid;
  logic [W-1:0] ak_out;
  logic [1:0]   phase;
  logic [3:0]   round_idx;
  logic         busy;

  modport master (
    output key_valid, key_in, adv,
    input  key_ready, ak_valid, ak_out, phase, round_idx, busy
  );

  modport slave (
    input  key_valid, key_in, adv,
    output key_ready, ak_valid, ak_out, phase, round_idx, busy
  );

endinterface
`default_nettype wire

// File: rtl/speedy_key_perm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : speedy_key_perm                                           |
// | Purpose  : Pure-wiring key permutation P_K, j -> (7*j+1) mod W.      |
// |            A decryption-key generator would instead use the inverse  |
// |            map j -> 55*(j-1) mod W.                                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module speedy_key_perm
  import speedy_pkg::*;
(
  input  wire logic [W-1:0] key_i,
  output logic      [W-1:0] perm_o
);

  // 7 is coprime with 192, so every output bit has exactly one source
  for (genvar j = 0; j < W; j++) begin : g_bit
    localparam int DST = (7 * j + 1) % W;
    assign perm_o[DST] = key_i[j];
  end

endmodule
`default_nettype wire

// File: rtl/speedy_ac_ak_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : speedy_ac_ak_sched                                        |
// | Purpose  : Iterative round-key / round-constant scheduler. Emits     |
// |            k_0, then c_r ^ k_{r+1} for r=0..NR-2, then k_NR, one     |
// |            word per controller advance.                              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module speedy_ac_ak_sched
  import speedy_pkg::*;
#(
  parameter int NR = 6
) (
  input wire logic           clk,
  input wire logic           rst,
  speedy_ac_ak_sched_if.slave bus
);

  localparam logic [3:0] LAST_R = 4'(NR - 2);
  localparam logic [3:0] FIN_R  = 4'(NR);

  state_t       state_q, state_d;
  logic [W-1:0] key_q,   key_d;
  logic [W-1:0] ak_q,    ak_d;
  logic [1:0]   phase_q, phase_d;
  logic [3:0]   ridx_q,  ridx_d;

  logic [W-1:0] w_key_next;
  logic [3:0]   w_rc_idx;
  logic [W-1:0] w_rc;

  speedy_key_perm u_perm (
    .key_i  (key_q),
    .perm_o (w_key_next)
  );

  // Constant for the word being produced: c_0 when leaving WHITEN,
  // c_{r+1} when stepping inside ROUND
  assign w_rc_idx = (state_q == ST_ROUND) ? (ridx_q + 4'd1) : 4'd0;
  assign w_rc     = RC_ROM[w_rc_idx];

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      ak_q    <= '0;
      phase_q <= PH_WHITEN;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ak_q    <= ak_d;
      phase_q <= phase_d;
      ridx_q  <= ridx_d;
    end
  end

  // Next-state: the key register always runs one round ahead of ak_out
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    ak_d    = ak_q;
    phase_d = phase_q;
    ridx_d  = ridx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.key_valid) begin
          key_d   = bus.key_in;
          ak_d    = bus.key_in;
          phase_d = PH_WHITEN;
          ridx_d  = '0;
          state_d = ST_WHITEN;
        end
      end
      ST_WHITEN: begin
        if (bus.adv) begin
          key_d   = w_key_next;
          ak_d    = w_rc ^ w_key_next;
          phase_d = PH_ROUND;
          ridx_d  = '0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (bus.adv) begin
          key_d = w_key_next;
          if (ridx_q == LAST_R) begin
            ak_d    = w_key_next;
            phase_d = PH_FINAL;
            ridx_d  = FIN_R;
            state_d = ST_FINAL;
          end else begin
            ak_d   = w_rc ^ w_key_next;
            ridx_d = ridx_q + 4'd1;
          end
        end
      end
      ST_FINAL: begin
        if (bus.adv) begin
          key_d   = '0;
          ak_d    = '0;
          phase_d = PH_WHITEN;
          ridx_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.key_ready = (state_q == ST_IDLE);
  assign bus.ak_valid  = (state_q != ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.ak_out    = ak_q;
  assign bus.phase     = phase_q;
  assign bus.round_idx = ridx_q;

endmodule
`default_nettype wire

// File: doc/speedy_ac_ak_sched.md
Name: speedy_ac_ak_sched

Overview:
- Sequential round-key and round-constant scheduler for the Speedy-6-192 iterative datapath.
- Accepts a 192-bit master key. Once per round it produces the 192-bit AC_AK word consumed by the MixColumns/AddConstant/AddKey stage.
- The next round's key is pre-merged with the current round's constant, so the MC stage performs constant addition and next-key addition in one XOR layer.
- Also produces the pre-whitening key k_0 and the final key k_R for the datapath controller.

Parameters:
- NR, 6, number of rounds R; legal range 2..15.
- W, 192, state/key width (6*32); fixed, not user-overridable in practice.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  master key offered
- key_ready  out  1  scheduler idle, key accepted when key_valid&&key_ready
- key_in  in  192  master key k_0, bit i*6+j = column i, row j
- adv  in  1  controller consumed current ak_out; advance to the next word
- ak_valid  out  1  ak_out holds a valid word
- ak_out  out  192  current word: k_0, then c_r^k_{r+1}, then k_R
- phase  out  2  0=WHITEN (k_0), 1=ROUND (c_r^k_{r+1}), 2=FINAL (k_R)
- round_idx  out  4  r for the current word (0 in WHITEN, R in FINAL)
- busy  out  1  schedule in progress

Behaviour:
Reset:
- Outputs: key_ready=1, ak_valid=0, ak_out=0, phase=0, round_idx=0, busy=0.
- Key register cleared; FSM enters IDLE.

Key schedule:
- k_{r+1} = P_K(k_r), where bit j of k_r moves to position (7*j+1) mod 192.
- P_K is pure wiring; exactly one register stage per round.

Constants:
- c_r for r=0..R-2 are taken from the package ROM, indexed by round_idx.

FSM: IDLE, WHITEN, ROUND, FINAL.
- IDLE:
  - key_ready=1. On key_valid: latch key_in into the key register, go to WHITEN next cycle.
  - Outputs (next cycle): ak_out=k_0, phase=0, round_idx=0, ak_valid=1, busy=1.
- WHITEN:
  - Hold outputs until adv. On adv, key register <= P_K(k), round_idx<=0.
  - Next cycle: ak_out = c_0 ^ k_1, phase=1.
- ROUND (round_idx=r):
  - Hold until adv.
  - On adv with r<R-2: r<=r+1, key <= P_K(key), ak_out = c_{r+1} ^ k_{r+2}.
  - On adv with r=R-2: go to FINAL, round_idx<=R, ak_out=k_R, phase=2.
  - The key register therefore always holds k_{r+1} while in ROUND.
- FINAL:
  - Hold until adv. On adv: IDLE, ak_valid=0, busy=0, key_ready=1.

Timing and handshake rules:
- Latency: first valid word 1 cycle after key acceptance; 1 cycle per adv. A full schedule is R+1 words.
- ak_out, phase and round_idx are registered, with no combinational path from adv.
- Outputs are stable while ak_valid=1 and adv=0.
- adv is ignored when ak_valid=0.
- key_valid is ignored while busy; no key is queued.
- A new key is accepted in the first IDLE cycle after FINAL+adv. The FINAL->IDLE->WHITEN sequence costs one idle cycle.
- rst asserted mid-schedule returns the block to the reset state on the next edge. The key register is cleared and no partial word remains valid.

Decomposition:
- Package speedy_pkg:
  - W=192, NCOL=32, NROW=6.
  - Phase encodings PH_WHITEN/PH_ROUND/PH_FINAL.
  - Function pk_perm(logic[191:0]) implementing P_K.
  - RC ROM constant array (15 entries x 192 bits) holding the pi-derived Speedy round constants.
- Sub-module speedy_key_perm: combinational P_K wiring only, shared with a future decryption-key generator that needs the inverse permutation (j -> 55*(j-1) mod 192).

Test Plan:
- Zero key: key_in=0, pulse adv 6 times → words 0, c_0, c_1, c_2, c_3, c_4, 0 with phase 0,1,1,1,1,1,2 and round_idx 0,0,1,2,3,4,6; key_ready returns 1 after the final adv.
- Single-bit tracking, key_in=1<<0: after first adv, k_1 has bit 1 set, so ak_out=c_0^(1<<1). Next: c_1^(1<<8). Final: bit (7*...)-chain position 4 steps further, checked against a reference model.
- Wrap case, key_in=1<<191: k_1 = 1<<186 (7*191+1 = 1338, mod 192 = 186); ak_out after first adv = c_0^(1<<186).
- Hold and ignore: hold adv=0 for 10 cycles in ROUND → ak_out unchanged. Assert key_valid with a different key while busy → key_ready=0 and the schedule is unaffected.
- Reset mid-schedule: assert rst at round_idx=2 → next cycle ak_valid=0, key_ready=1, ak_out=0. A new key then restarts at phase 0.
- Back-to-back: key_valid held high continuously with two keys → second key accepted exactly one cycle after FINAL+adv; no word of key A appears after the first WHITEN of key B.
